// File: rtl/hht_mem_pkg.sv
// Shared constants, FSM state type and size-clamp helper for the HHT memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hht_mem_pkg;

  // Value returned for any address outside its window or when no read is valid
  localparam logic [31:0] DEFAULT_WORD = 32'd99999;

  // Column and v_values bank depths in words
  localparam int COL_DEPTH = 128;
  localparam int V_DEPTH   = 32;

  // Address widths for the two banks
  localparam int COL_AW = $clog2(COL_DEPTH);
  localparam int V_AW   = $clog2(V_DEPTH);

  // Load / serve FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LD_COL = 2'd1,
    LD_VEC = 2'd2,
    READY  = 2'd3
  } state_t;

  // Clamp a requested word count to a bank depth; result fits in 8 bits (max 128)
  function automatic logic [7:0] clamp_size(input logic [31:0] size, input logic [7:0] limit);
    return (size > {24'd0, limit}) ? limit : size[7:0];
  endfunction

endpackage

// File: rtl/hht_mem_bank.sv
// Single-write, single-read word bank used for both the column and v_values arrays.
// Latency: write takes effect on the next edge; read data is registered, 1 cycle.
// Backpressure: none; one write and one read may be issued every cycle.
module hht_mem_bank #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [31:0]   i_wr_dat,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_dat
);

  // Contents are deliberately not reset: a reload is required after reset anyway
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd_dat;

  // Synchronous write port
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  // Registered read port; holds its last value when not enabled
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_dat <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/hht_mem_responder.sv
// Loads a column window and a v_values window from a word stream, then serves windowed reads.
// Latency: reads return 1 cycle after RD; ld_done pulses the cycle after the last load word.
// Backpressure: ld_ready is high only while loading; reads are accepted every cycle in READY.
module hht_mem_responder
  import hht_mem_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] col_base,
  input  logic [31:0] v_base,
  input  logic [31:0] csize,
  input  logic [31:0] vsize,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        ld_done,
  input  logic        RD,
  input  logic [31:0] addr1,
  input  logic [31:0] addr2,
  output logic [31:0] dataIn1,
  output logic [31:0] dataIn2,
  output logic        rvalid
);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_col_base;
  logic [31:0] r_v_base;
  logic [7:0]  r_csize;
  logic [7:0]  r_vsize;
  logic        r_ld_ready;
  logic        r_ld_done;
  logic        r_rvalid;
  logic        r_col_hit;
  logic        r_v_hit;

  logic        w_ld_acc;
  logic        w_col_we;
  logic        w_v_we;
  logic        w_col_last;
  logic        w_vec_last;
  logic        w_load_end;
  logic        w_rd_en;
  logic [32:0] w_col_end;
  logic [32:0] w_v_end;
  logic        w_col_hit;
  logic        w_v_hit;
  logic [COL_AW-1:0] w_col_off;
  logic [V_AW-1:0]   w_v_off;
  logic [31:0] w_col_rdat;
  logic [31:0] w_v_rdat;

  // A load word moves only on a valid/ready handshake; zero-size windows never write
  assign w_ld_acc = ld_valid && r_ld_ready;
  assign w_col_we = (r_state == LD_COL) && w_ld_acc && (r_csize != 8'd0);
  assign w_v_we   = (r_state == LD_VEC) && w_ld_acc && (r_vsize != 8'd0);

  // End of each load phase; an empty window ends its phase after one cycle
  assign w_col_last = (r_state == LD_COL) &&
                      ((r_csize == 8'd0) || (w_col_we && (r_cnt == r_csize - 8'd1)));
  assign w_vec_last = (r_state == LD_VEC) &&
                      ((r_vsize == 8'd0) || (w_v_we && (r_cnt == r_vsize - 8'd1)));
  // An empty v window skips LD_VEC entirely once the column phase completes
  assign w_load_end = (w_col_last && (r_vsize == 8'd0)) || w_vec_last;

  assign w_rd_en = RD && (r_state == READY);

  // Window ends carry an extra bit so a window near the top of the address space cannot wrap
  assign w_col_end = {1'b0, r_col_base} + {25'd0, r_csize};
  assign w_v_end   = {1'b0, r_v_base}   + {25'd0, r_vsize};
  assign w_col_hit = (addr1 >= r_col_base) && ({1'b0, addr1} < w_col_end);
  assign w_v_hit   = (addr2 >= r_v_base)   && ({1'b0, addr2} < w_v_end);

  // In-window offsets; only meaningful (and only used) when the matching hit is set
  assign w_col_off = COL_AW'(addr1 - r_col_base);
  assign w_v_off   = V_AW'(addr2 - r_v_base);

  // Load FSM, window configuration capture and read-qualifier registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_col_base <= 32'd0;
      r_v_base   <= 32'd0;
      r_csize    <= 8'd0;
      r_vsize    <= 8'd0;
      r_ld_ready <= 1'b0;
      r_ld_done  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_col_hit  <= 1'b0;
      r_v_hit    <= 1'b0;
    end else begin
      r_ld_done <= 1'b0;
      r_rvalid  <= w_rd_en;
      r_col_hit <= w_rd_en && w_col_hit;
      r_v_hit   <= w_rd_en && w_v_hit;

      case (r_state)
        IDLE, READY: begin
          if (ld_start) begin
            r_col_base <= col_base;
            r_v_base   <= v_base;
            r_csize    <= clamp_size(csize, 8'(COL_DEPTH));
            r_vsize    <= clamp_size(vsize, 8'(V_DEPTH));
            r_cnt      <= 8'd0;
            r_ld_ready <= 1'b1;
            r_state    <= LD_COL;
          end
        end
        LD_COL: begin
          if (w_col_last) begin
            r_cnt <= 8'd0;
            if (w_load_end) begin
              r_state    <= READY;
              r_ld_ready <= 1'b0;
              r_ld_done  <= 1'b1;
            end else begin
              r_state <= LD_VEC;
            end
          end else if (w_col_we) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        LD_VEC: begin
          if (w_vec_last) begin
            r_cnt      <= 8'd0;
            r_state    <= READY;
            r_ld_ready <= 1'b0;
            r_ld_done  <= 1'b1;
          end else if (w_v_we) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_ld_ready <= 1'b0;
        end
      endcase
    end
  end

  hht_mem_bank #(.DEPTH(COL_DEPTH)) u_col_bank (
    .i_clk     (Clk),
    .i_wr_en   (w_col_we),
    .i_wr_addr (r_cnt[COL_AW-1:0]),
    .i_wr_dat  (ld_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_col_off),
    .o_rd_dat  (w_col_rdat)
  );

  hht_mem_bank #(.DEPTH(V_DEPTH)) u_v_bank (
    .i_clk     (Clk),
    .i_wr_en   (w_v_we),
    .i_wr_addr (r_cnt[V_AW-1:0]),
    .i_wr_dat  (ld_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_v_off),
    .o_rd_dat  (w_v_rdat)
  );

  assign ld_ready = r_ld_ready;
  assign ld_done  = r_ld_done;
  assign rvalid   = r_rvalid;
  // Registered hit flags select bank data or the default word; both flags clear on reset
  assign dataIn1  = r_col_hit ? w_col_rdat : DEFAULT_WORD;
  assign dataIn2  = r_v_hit   ? w_v_rdat   : DEFAULT_WORD;

endmodule

// File: tb/tb_hht_mem_responder.sv
// Self-checking bench for hht_mem_responder: directed loads and reads against a behavioural model.
// Latency: model predicts outputs one edge after the inputs that cause them.
// Backpressure: load driver holds each word until the handshake completes.
module tb_hht_mem_responder;

  localparam logic [31:0] DEF = 32'd99999;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] col_base = 32'd0;
  logic [31:0] v_base   = 32'd0;
  logic [31:0] csize    = 32'd0;
  logic [31:0] vsize    = 32'd0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data  = 32'd0;
  logic        RD       = 1'b0;
  logic [31:0] addr1    = 32'd0;
  logic [31:0] addr2    = 32'd0;
  logic        ld_ready;
  logic        ld_done;
  logic [31:0] dataIn1;
  logic [31:0] dataIn2;
  logic        rvalid;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  hht_mem_responder dut (
    .Clk(Clk), .Rst(Rst), .col_base(col_base), .v_base(v_base),
    .csize(csize), .vsize(vsize), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done), .RD(RD),
    .addr1(addr1), .addr2(addr2), .dataIn1(dataIn1), .dataIn2(dataIn2),
    .rvalid(rvalid)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Test data: salt 0 pins a few hand-picked words, other salts give distinct patterns
  function automatic logic [31:0] col_word(input int i, input int salt);
    if (salt == 0) begin
      case (i)
        0: return 32'd11;
        1: return 32'd2;
        2: return 32'd6;
        3: return 32'd17;
        4: return 32'd23;
        5: return 32'd31;
        default: ;
      endcase
    end
    return 32'((i * 7 + 3) % 100 + salt * 1000);
  endfunction

  function automatic logic [31:0] v_word(input int i, input int salt);
    if (salt == 0) begin
      case (i)
        0:  return 32'd78;
        1:  return 32'd59;
        13: return 32'd94;
        default: ;
      endcase
    end
    return 32'((i * 13 + 5) % 97 + salt * 1000 + 200);
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 = no valid contents, 1 = loading, 2 = serving reads
  int          m_mode = 0;
  longint      m_cb, m_vb;
  int          m_cs, m_vs, m_k;
  bit          m_dead;
  logic [31:0] m_col [128];
  logic [31:0] m_v   [32];
  logic        e_rdy, e_done, e_rv;
  logic [31:0] e_d1, e_d2;

  always @(posedge Clk) begin
    if (Rst) begin
      m_mode = 0;
      e_rdy = 1'b0; e_done = 1'b0; e_rv = 1'b0; e_d1 = DEF; e_d2 = DEF;
    end else begin
      longint a1, a2;
      a1 = {32'd0, addr1};
      a2 = {32'd0, addr2};
      e_done = 1'b0;
      e_d1 = DEF;
      e_d2 = DEF;
      e_rv = (m_mode == 2) && RD;
      if (e_rv) begin
        if (a1 >= m_cb && a1 < m_cb + m_cs) e_d1 = m_col[int'(a1 - m_cb)];
        if (a2 >= m_vb && a2 < m_vb + m_vs) e_d2 = m_v[int'(a2 - m_vb)];
      end
      if ((m_mode == 0 || m_mode == 2) && ld_start) begin
        m_cb = {32'd0, col_base};
        m_vb = {32'd0, v_base};
        m_cs = (csize > 32'd128) ? 128 : int'(csize);
        m_vs = (vsize > 32'd32)  ? 32  : int'(vsize);
        m_k = 0;
        m_dead = (m_cs == 0);
        m_mode = 1;
        e_rdy = 1'b1;
      end else if (m_mode == 1) begin
        bit fin;
        fin = 1'b0;
        if (m_dead) begin
          m_dead = 1'b0;
          fin = (m_vs == 0);
        end else if (ld_valid) begin
          if (m_k < m_cs) m_col[m_k] = ld_data;
          else            m_v[m_k - m_cs] = ld_data;
          m_k++;
          fin = (m_k == m_cs + m_vs);
        end
        if (fin) begin
          m_mode = 2;
          e_rdy = 1'b0;
          e_done = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge Clk) begin
    if (chk_on) begin
      chk("ld_ready", {31'd0, ld_ready}, {31'd0, e_rdy});
      chk("ld_done",  {31'd0, ld_done},  {31'd0, e_done});
      chk("rvalid",   {31'd0, rvalid},   {31'd0, e_rv});
      chk("dataIn1",  dataIn1, e_d1);
      chk("dataIn2",  dataIn2, e_d2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_load(input logic [31:0] cb, input logic [31:0] cs, input logic [31:0] vb,
                         input logic [31:0] vs, input int salt, input bit toggle,
                         input int restart_at, output int cyc);
    int csc, n, j;
    bit rdy;
    csc = (cs > 32'd128) ? 128 : int'(cs);
    n   = csc + ((vs > 32'd32) ? 32 : int'(vs));
    @(negedge Clk);
    col_base = cb; csize = cs; v_base = vb; vsize = vs;
    ld_start = 1'b1; ld_valid = 1'b0;
    @(negedge Clk);
    ld_start = 1'b0;
    j = 0;
    cyc = 0;
    forever begin
      ld_valid = (toggle ? (cyc % 2 == 0) : 1'b1) && (j < n);
      ld_data  = (j < csc) ? col_word(j, salt) : v_word(j - csc, salt);
      ld_start = (cyc == restart_at);
      rdy = ld_ready;
      @(negedge Clk);
      cyc++;
      if (ld_valid && rdy) j++;
      if (ld_done) break;
      if (cyc > 3000) begin
        chk("load_timeout", 32'd0, 32'd1);
        break;
      end
    end
    ld_valid = 1'b0;
    ld_start = 1'b0;
    // Scramble configuration inputs: the captured copy must be the one in use
    col_base = 32'h1234_5678; v_base = 32'h0BAD_0000; csize = 32'd1; vsize = 32'd1;
  endtask

  task automatic rd(input logic [31:0] a1, input logic [31:0] a2);
    @(negedge Clk);
    RD = 1'b1; addr1 = a1; addr2 = a2;
    @(negedge Clk);
    RD = 1'b0;
  endtask

  initial begin
    int cyc;
    @(posedge Clk);
    chk_on = 1'b1;
    @(negedge Clk);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_rvalid",   {31'd0, rvalid},   32'd0);
    chk("rst_dataIn1",  dataIn1, DEF);
    chk("rst_dataIn2",  dataIn2, DEF);
    Rst = 1'b0;

    // Full load with valid held high
    do_load(32'd340, 32'd102, 32'd2, 32'd32, 0, 1'b0, -1, cyc);
    chk("done_latency_full", cyc, 32'd134);
    rd(32'd345, 32'd15);
    chk("rd_345_d1", dataIn1, 32'd31);
    chk("rd_15_d2",  dataIn2, 32'd94);
    chk("rd_345_rv", {31'd0, rvalid}, 32'd1);
    rd(32'd442, 32'd34);
    chk("rd_442_d1", dataIn1, DEF);
    chk("rd_34_d2",  dataIn2, DEF);
    chk("rd_442_rv", {31'd0, rvalid}, 32'd1);
    rd(32'd339, 32'd1);
    chk("rd_339_d1", dataIn1, DEF);
    chk("rd_1_d2",   dataIn2, DEF);
    rd(32'd441, 32'd33);
    chk("rd_441_d1", dataIn1, 32'd10);
    chk("rd_33_d2",  dataIn2, 32'd220);

    // Load with ld_valid toggling, then back-to-back reads sweeping both windows
    do_load(32'd340, 32'd102, 32'd2, 32'd32, 1, 1'b1, -1, cyc);
    chk("done_latency_toggle", cyc, 32'd267);
    @(negedge Clk);
    RD = 1'b1;
    for (int i = 0; i < 104; i++) begin
      addr1 = 32'd339 + 32'(i);
      addr2 = 32'(i);
      @(negedge Clk);
    end
    RD = 1'b0;
    rd(32'd345, 32'd15);
    chk("toggle_col5", dataIn1, 32'd1038);
    chk("toggle_v13",  dataIn2, 32'd1277);

    // Reset after 50 column words
    @(negedge Clk);
    col_base = 32'd340; csize = 32'd102; v_base = 32'd2; vsize = 32'd32;
    ld_start = 1'b1;
    @(negedge Clk);
    ld_start = 1'b0;
    ld_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      ld_data = col_word(k, 2);
      @(negedge Clk);
    end
    Rst = 1'b1;
    ld_valid = 1'b0;
    @(negedge Clk);
    chk("midrst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("midrst_ld_done",  {31'd0, ld_done},  32'd0);
    Rst = 1'b0;
    rd(32'd345, 32'd15);
    chk("midrst_rv", {31'd0, rvalid}, 32'd0);
    chk("midrst_d1", dataIn1, DEF);
    chk("midrst_d2", dataIn2, DEF);

    // Clamped csize, empty v window, window at top of address space, ignored ld_start
    do_load(32'hFFFF_FF80, 32'd200, 32'd500, 32'd0, 3, 1'b0, 5, cyc);
    chk("done_latency_clamp", cyc, 32'd128);
    rd(32'hFFFF_FFFF, 32'd500);
    chk("clamp_last_d1", dataIn1, 32'd3092);
    chk("clamp_v_empty", dataIn2, DEF);
    chk("clamp_rv", {31'd0, rvalid}, 32'd1);
    rd(32'd0, 32'd499);
    chk("clamp_wrap_d1", dataIn1, DEF);
    rd(32'hFFFF_FF80, 32'd0);
    chk("clamp_first_d1", dataIn1, 32'd3003);

    // Reload from READY with overlapping windows and shared addresses
    do_load(32'd100, 32'd40, 32'd110, 32'd8, 4, 1'b0, -1, cyc);
    chk("done_latency_ovl", cyc, 32'd48);
    rd(32'd112, 32'd112);
    chk("ovl_same_d1", dataIn1, 32'd4087);
    chk("ovl_same_d2", dataIn2, 32'd4231);
    rd(32'd118, 32'd117);
    chk("ovl_d1", dataIn1, 32'd4029);
    chk("ovl_d2", dataIn2, 32'd4296);

    repeat (3) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
